perf_counter_bank: RTL and testbench

Synthesizable, software-visible performance counter bank for the pipelined core. It generalises the testbench-only performance monitoring into RTL: NUM_COUNTERS programmable counters, each selecting one of NUM_EVENTS single-bit event inputs driven by the pipeline (retire, load stall, branch mispredict, icache miss, ...). It supports level or rising-edge counting, wrap or saturate, sticky overflow with interrupt, and an atomic snapshot. It sits beside the core and is accessed through a simple register read/write port.

---
 rtl/perf_pkg.sv | 57 +++++
 rtl/perf_counter_channel.sv | 78 +++++++
 rtl/perf_counter_bank.sv | 161 ++++++++++++++++
 tb/tb_perf_counter_bank.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// Shared definitions for the performance counter bank: register map,
// CTRL field layout and the per-counter control struct.
package perf_pkg;

    localparam int CFG_ADDR_W = 6;
    localparam int SEL_W      = 6;
    localparam int MAX_EVENTS = 2 ** SEL_W;

    // The upper two address bits select a register region, the lower four the counter index.
    localparam logic [1:0] REGION_GLOBAL = 2'd0;
    localparam logic [1:0] REGION_CTRL   = 2'd1;
    localparam logic [1:0] REGION_CNT    = 2'd2;
    localparam logic [1:0] REGION_SNAP   = 2'd3;

    localparam logic [CFG_ADDR_W-1:0] ADDR_GCTRL     = 6'h00;
    localparam logic [CFG_ADDR_W-1:0] ADDR_OVF       = 6'h01;
    localparam logic [CFG_ADDR_W-1:0] ADDR_IRQMASK   = 6'h02;
    localparam logic [CFG_ADDR_W-1:0] ADDR_CTRL_BASE = {REGION_CTRL, 4'h0};
    localparam logic [CFG_ADDR_W-1:0] ADDR_CNT_BASE  = {REGION_CNT, 4'h0};
    localparam logic [CFG_ADDR_W-1:0] ADDR_SNAP_BASE = {REGION_SNAP, 4'h0};

    localparam int GCTRL_EN_BIT  = 0;
    localparam int GCTRL_CLR_BIT = 1;

    localparam int CTRL_SEL_LSB  = 0;
    localparam int CTRL_SEL_MSB  = CTRL_SEL_LSB + SEL_W - 1;
    localparam int CTRL_EN_BIT   = 8;
    localparam int CTRL_EDGE_BIT = 9;
    localparam int CTRL_SAT_BIT  = 10;

    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic             en;
        logic             edge_mode;
        logic             sat;
    } perf_ctrl_t;

    function automatic perf_ctrl_t ctrl_from_word(input logic [31:0] word);
        perf_ctrl_t ctrl;
        ctrl.sel       = word[CTRL_SEL_MSB:CTRL_SEL_LSB];
        ctrl.en        = word[CTRL_EN_BIT];
        ctrl.edge_mode = word[CTRL_EDGE_BIT];
        ctrl.sat       = word[CTRL_SAT_BIT];
        return ctrl;
    endfunction

    function automatic logic [31:0] ctrl_to_word(input perf_ctrl_t ctrl);
        logic [31:0] word;
        word                             = '0;
        word[CTRL_SEL_MSB:CTRL_SEL_LSB]  = ctrl.sel;
        word[CTRL_EN_BIT]                = ctrl.en;
        word[CTRL_EDGE_BIT]              = ctrl.edge_mode;
        word[CTRL_SAT_BIT]               = ctrl.sat;
        return word;
    endfunction

endpackage

// File: rtl/perf_counter_channel.sv
// One counter channel: event select, level/edge hit, wrap or saturate,
// overflow pulse, software load/clear and the snapshot shadow register.
module perf_counter_channel
    import perf_pkg::*;
#(
    parameter int NUM_EVENTS = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [NUM_EVENTS-1:0] events_i,
    input  logic [NUM_EVENTS-1:0] prev_i,
    input  logic                  count_en_i,
    input  perf_ctrl_t            ctrl_i,
    input  logic                  clear_i,
    input  logic                  load_i,
    input  logic [CNT_WIDTH-1:0]  load_val_i,
    input  logic                  snapshot_i,
    output logic [CNT_WIDTH-1:0]  cnt_o,
    output logic [CNT_WIDTH-1:0]  snap_o,
    output logic                  ovf_o
);

    logic [MAX_EVENTS-1:0] events_ext;
    logic [MAX_EVENTS-1:0] prev_ext;
    logic                  hit;
    logic                  inc;
    logic                  at_max;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]  snap_q, snap_d;

    // Widening to the full select range makes any sel >= NUM_EVENTS read a constant 0.
    always_comb begin
        events_ext                   = '0;
        prev_ext                     = '0;
        events_ext[NUM_EVENTS-1:0]   = events_i;
        prev_ext[NUM_EVENTS-1:0]     = prev_i;
    end

    assign hit    = events_ext[ctrl_i.sel] & ~(ctrl_i.edge_mode & prev_ext[ctrl_i.sel]);
    assign inc    = count_en_i & ctrl_i.en & hit;
    assign at_max = &cnt_q;
    // A clear or load in the same cycle overrides the increment, so it cannot overflow either.
    assign ovf_o  = inc & at_max & ~clear_i & ~load_i;

    // NOTE: every path below starts from a default, so no branch leaves cnt_d unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc) begin
            if (!at_max) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end else if (!ctrl_i.sat) begin
                cnt_d = '0;
            end
        end
    end

    assign snap_d = snapshot_i ? cnt_q : snap_q;

    // NOTE: non-blocking assignments make the shadow capture the pre-edge counter even when both update together.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            cnt_q  <= '0;
            snap_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            snap_q <= snap_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign snap_o = snap_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Software-visible performance counter bank: register decode, read port,
// global/overflow/interrupt state and NUM_COUNTERS counter channels.
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int NUM_EVENTS   = 16,
    parameter int NUM_COUNTERS = 4,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [NUM_EVENTS-1:0] events_i,
    input  logic                  freeze_i,
    input  logic                  snapshot_i,
    input  logic                  cfg_we_i,
    input  logic [5:0]            cfg_addr_i,
    input  logic [31:0]           cfg_wdata_i,
    input  logic                  rd_en_i,
    output logic [31:0]           rd_data_o,
    output logic                  rd_valid_o,
    output logic                  irq_o
);

    logic [NUM_EVENTS-1:0]   prev_q;
    logic                    gen_q, gen_d;
    logic [NUM_COUNTERS-1:0] ovf_q, ovf_d;
    logic [NUM_COUNTERS-1:0] irqmask_q, irqmask_d;
    logic [NUM_COUNTERS-1:0] ovf_set;
    logic                    irq_q;
    perf_ctrl_t              ctrl_q [NUM_COUNTERS];
    perf_ctrl_t              ctrl_d [NUM_COUNTERS];
    logic [CNT_WIDTH-1:0]    cnt    [NUM_COUNTERS];
    logic [CNT_WIDTH-1:0]    snap   [NUM_COUNTERS];
    logic [31:0]             rd_mux;
    logic [31:0]             rd_data_q, rd_data_d;
    logic                    rd_valid_q;

    logic [1:0]              addr_region;
    logic [3:0]              addr_idx;
    logic                    wr_gctrl;
    logic                    clear_all;
    logic                    count_en;
    logic [NUM_COUNTERS-1:0] ctrl_we;
    logic [NUM_COUNTERS-1:0] cnt_we;

    assign addr_region = cfg_addr_i[5:4];
    assign addr_idx    = cfg_addr_i[3:0];
    assign wr_gctrl    = cfg_we_i && (cfg_addr_i == ADDR_GCTRL);
    // Clear-all zeroes the live counters only; shadows, OVF and configuration are kept.
    assign clear_all   = wr_gctrl && cfg_wdata_i[GCTRL_CLR_BIT];
    assign count_en    = gen_q & ~freeze_i;

    always_comb begin
        for (int c = 0; c < NUM_COUNTERS; c++) begin
            ctrl_we[c] = cfg_we_i && (addr_region == REGION_CTRL) && (addr_idx == 4'(c));
            cnt_we[c]  = cfg_we_i && (addr_region == REGION_CNT) && (addr_idx == 4'(c));
        end
    end

    for (genvar g = 0; g < NUM_COUNTERS; g++) begin : g_chan
        perf_counter_channel #(
            .NUM_EVENTS (NUM_EVENTS),
            .CNT_WIDTH  (CNT_WIDTH)
        ) u_chan (
            .clk_i      (clk_i),
            .reset_i    (reset_i),
            .events_i   (events_i),
            .prev_i     (prev_q),
            .count_en_i (count_en),
            .ctrl_i     (ctrl_q[g]),
            .clear_i    (clear_all),
            .load_i     (cnt_we[g]),
            .load_val_i (cfg_wdata_i[CNT_WIDTH-1:0]),
            .snapshot_i (snapshot_i),
            .cnt_o      (cnt[g]),
            .snap_o     (snap[g]),
            .ovf_o      (ovf_set[g])
        );
    end

    // A new overflow is OR-ed in after the W1C mask so a concurrent clear cannot lose it.
    always_comb begin
        gen_d     = gen_q;
        irqmask_d = irqmask_q;
        ovf_d     = ovf_q;
        ctrl_d    = ctrl_q;
        if (wr_gctrl) begin
            gen_d = cfg_wdata_i[GCTRL_EN_BIT];
        end
        if (cfg_we_i && (cfg_addr_i == ADDR_IRQMASK)) begin
            irqmask_d = cfg_wdata_i[NUM_COUNTERS-1:0];
        end
        if (cfg_we_i && (cfg_addr_i == ADDR_OVF)) begin
            ovf_d = ovf_q & ~cfg_wdata_i[NUM_COUNTERS-1:0];
        end
        ovf_d = ovf_d | ovf_set;
        for (int c = 0; c < NUM_COUNTERS; c++) begin
            if (ctrl_we[c]) begin
                ctrl_d[c] = ctrl_from_word(cfg_wdata_i);
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        if (addr_region == REGION_GLOBAL) begin
            case (cfg_addr_i)
                ADDR_GCTRL:   rd_mux[GCTRL_EN_BIT]     = gen_q;
                ADDR_OVF:     rd_mux[NUM_COUNTERS-1:0] = ovf_q;
                ADDR_IRQMASK: rd_mux[NUM_COUNTERS-1:0] = irqmask_q;
                default:      rd_mux                   = '0;
            endcase
        end else begin
            for (int c = 0; c < NUM_COUNTERS; c++) begin
                if (addr_idx == 4'(c)) begin
                    case (addr_region)
                        REGION_CTRL: rd_mux                  = ctrl_to_word(ctrl_q[c]);
                        REGION_CNT:  rd_mux[CNT_WIDTH-1:0]   = cnt[c];
                        REGION_SNAP: rd_mux[CNT_WIDTH-1:0]   = snap[c];
                        default:     rd_mux                  = '0;
                    endcase
                end
            end
        end
    end

    // Read data holds between reads; the mux sees pre-write state, so read-during-write returns the old value.
    assign rd_data_d = rd_en_i ? rd_mux : rd_data_q;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            prev_q     <= '0;
            gen_q      <= 1'b0;
            ovf_q      <= '0;
            irqmask_q  <= '0;
            irq_q      <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            // NOTE: the CTRL array is software-visible configuration, so every entry is reset, unlike a bulk data RAM.
            for (int c = 0; c < NUM_COUNTERS; c++) begin
                ctrl_q[c] <= '0;
            end
        end else begin
            prev_q     <= events_i;
            gen_q      <= gen_d;
            ovf_q      <= ovf_d;
            irqmask_q  <= irqmask_d;
            irq_q      <= |(ovf_q & irqmask_q);
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_en_i;
            for (int c = 0; c < NUM_COUNTERS; c++) begin
                ctrl_q[c] <= ctrl_d[c];
            end
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign irq_o      = irq_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: a 32-bit and an 8-bit counter bank share all
// inputs and are compared every cycle against a register-level behavioural model.
module tb_perf_counter_bank;

    localparam int NE = 16;
    localparam int NC = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [NE-1:0] events;
    logic          freeze;
    logic          snapshot;
    logic          cfg_we;
    logic [5:0]    cfg_addr;
    logic [31:0]   cfg_wdata;
    logic          rd_en;
    logic [31:0]   rd_data  [2];
    logic          rd_valid [2];
    logic          irq      [2];

    always #5 clk = ~clk;

    perf_counter_bank #(.NUM_EVENTS(NE), .NUM_COUNTERS(NC), .CNT_WIDTH(32)) dut_w32 (
        .clk_i       (clk),
        .reset_i     (reset_n),
        .events_i    (events),
        .freeze_i    (freeze),
        .snapshot_i  (snapshot),
        .cfg_we_i    (cfg_we),
        .cfg_addr_i  (cfg_addr),
        .cfg_wdata_i (cfg_wdata),
        .rd_en_i     (rd_en),
        .rd_data_o   (rd_data[0]),
        .rd_valid_o  (rd_valid[0]),
        .irq_o       (irq[0])
    );

    perf_counter_bank #(.NUM_EVENTS(NE), .NUM_COUNTERS(NC), .CNT_WIDTH(8)) dut_w8 (
        .clk_i       (clk),
        .reset_i     (reset_n),
        .events_i    (events),
        .freeze_i    (freeze),
        .snapshot_i  (snapshot),
        .cfg_we_i    (cfg_we),
        .cfg_addr_i  (cfg_addr),
        .cfg_wdata_i (cfg_wdata),
        .rd_en_i     (rd_en),
        .rd_data_o   (rd_data[1]),
        .rd_valid_o  (rd_valid[1]),
        .irq_o       (irq[1])
    );

    // Reference model state; index [d] selects the 32-bit (0) or 8-bit (1) bank.
    logic [31:0]   m_cnt   [2][NC];
    logic [31:0]   m_snap  [2][NC];
    logic [NC-1:0] m_ovf   [2];
    logic          m_irq   [2];
    logic [31:0]   m_rd    [2];
    logic          m_valid;
    logic          m_gen;
    logic [NC-1:0] m_mask;
    logic [5:0]    m_sel   [NC];
    logic          m_en    [NC];
    logic          m_edge  [NC];
    logic          m_sat   [NC];
    logic [NE-1:0] m_prev;

    int    n_vec  = 0;
    int    n_miss = 0;
    string dn [2] = '{"w32", "w8"};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_miss++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cnt_max(input int d);
        return (d == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    endfunction

    function automatic logic [31:0] model_read(input int d, input logic [5:0] a);
        int c;
        c = int'(a[3:0]);
        if (a == 6'h00) return {31'd0, m_gen};
        if (a == 6'h01) return 32'(m_ovf[d]);
        if (a == 6'h02) return 32'(m_mask);
        if (c >= NC) return 32'd0;
        case (a[5:4])
            2'd1:    return (32'(m_sat[c]) << 10) | (32'(m_edge[c]) << 9) | (32'(m_en[c]) << 8) | 32'(m_sel[c]);
            2'd2:    return m_cnt[d][c];
            2'd3:    return m_snap[d][c];
            default: return 32'd0;
        endcase
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_tick();
        logic          clr;
        logic          hit;
        logic          inc;
        logic [NC-1:0] ovf_n;
        int            s;
        if (!reset_n) begin
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < NC; c++) begin
                    m_cnt[d][c]  = '0;
                    m_snap[d][c] = '0;
                end
                m_ovf[d] = '0;
                m_irq[d] = 1'b0;
                m_rd[d]  = '0;
            end
            for (int c = 0; c < NC; c++) begin
                m_sel[c]  = '0;
                m_en[c]   = 1'b0;
                m_edge[c] = 1'b0;
                m_sat[c]  = 1'b0;
            end
            m_valid = 1'b0;
            m_gen   = 1'b0;
            m_mask  = '0;
            m_prev  = '0;
            return;
        end
        m_valid = rd_en;
        clr     = cfg_we && (cfg_addr == 6'h00) && cfg_wdata[1];
        for (int d = 0; d < 2; d++) begin
            if (rd_en) m_rd[d] = model_read(d, cfg_addr);
            m_irq[d] = |(m_ovf[d] & m_mask);
            ovf_n    = m_ovf[d];
            if (cfg_we && (cfg_addr == 6'h01)) ovf_n = ovf_n & ~cfg_wdata[NC-1:0];
            for (int c = 0; c < NC; c++) begin
                s   = int'(m_sel[c]);
                hit = 1'b0;
                if (s < NE) hit = events[s] && !(m_edge[c] && m_prev[s]);
                inc = m_gen && m_en[c] && !freeze && hit;
                if (snapshot) m_snap[d][c] = m_cnt[d][c];
                if (clr) begin
                    m_cnt[d][c] = '0;
                end else if (cfg_we && (cfg_addr == 6'(32 + c))) begin
                    m_cnt[d][c] = cfg_wdata & cnt_max(d);
                end else if (inc) begin
                    if (m_cnt[d][c] == cnt_max(d)) begin
                        ovf_n[c] = 1'b1;
                        if (!m_sat[c]) m_cnt[d][c] = '0;
                    end else begin
                        m_cnt[d][c] = m_cnt[d][c] + 32'd1;
                    end
                end
            end
            m_ovf[d] = ovf_n;
        end
        if (cfg_we) begin
            if (cfg_addr == 6'h00) m_gen  = cfg_wdata[0];
            if (cfg_addr == 6'h02) m_mask = cfg_wdata[NC-1:0];
            for (int c = 0; c < NC; c++) begin
                if (cfg_addr == 6'(16 + c)) begin
                    m_sel[c]  = cfg_wdata[5:0];
                    m_en[c]   = cfg_wdata[8];
                    m_edge[c] = cfg_wdata[9];
                    m_sat[c]  = cfg_wdata[10];
                end
            end
        end
        m_prev = events;
    endtask

    task automatic tick();
        model_tick();
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("irq_o/%s", dn[d]), 32'(irq[d]), 32'(m_irq[d]));
            check($sformatf("rd_valid_o/%s", dn[d]), 32'(rd_valid[d]), 32'(m_valid));
            check($sformatf("rd_data_o/%s", dn[d]), rd_data[d], m_rd[d]);
        end
        cfg_we   = 1'b0;
        rd_en    = 1'b0;
        snapshot = 1'b0;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] v);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = v;
        tick();
    endtask

    task automatic rd_expect(input string tag, input logic [5:0] a, input logic [31:0] e32, input logic [31:0] e8);
        rd_en    = 1'b1;
        cfg_addr = a;
        tick();
        check({tag, "/w32"}, rd_data[0], e32);
        check({tag, "/w8"}, rd_data[1], e8);
    endtask

    task automatic check_irq(input string tag, input logic e);
        check({tag, "/w32"}, 32'(irq[0]), 32'(e));
        check({tag, "/w8"}, 32'(irq[1]), 32'(e));
    endtask

    initial begin
        int op;
        int pick;
        reset_n   = 1'b0;
        events    = '0;
        freeze    = 1'b0;
        snapshot  = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
        rd_en     = 1'b0;

        // Reset state
        repeat (2) tick();
        check("reset rd_data", rd_data[0], 32'd0);
        check("reset rd_valid", 32'(rd_valid[0]), 32'd0);
        check_irq("reset irq", 1'b0);
        reset_n = 1'b1;

        // Level count: five cycles of event 3
        wr(6'h10, 32'h0000_0103);
        wr(6'h00, 32'h0000_0001);
        events[3] = 1'b1;
        repeat (5) tick();
        events[3] = 1'b0;
        rd_expect("level cnt0", 6'h20, 32'd5, 32'd5);
        check("rd_valid one cycle", 32'(rd_valid[0]), 32'd1);
        tick();
        check("rd_valid drops", 32'(rd_valid[0]), 32'd0);
        check("rd_data holds", rd_data[0], 32'd5);

        // Edge versus level on event 2: high 3, low 1, high 2
        wr(6'h11, 32'h0000_0302);
        wr(6'h12, 32'h0000_0102);
        events[2] = 1'b1;
        repeat (3) tick();
        events[2] = 1'b0;
        tick();
        events[2] = 1'b1;
        repeat (2) tick();
        events[2] = 1'b0;
        tick();
        rd_expect("edge cnt1", 6'h21, 32'd2, 32'd2);
        rd_expect("level cnt2", 6'h22, 32'd5, 32'd5);
        events[2] = 1'b1;
        repeat (2) tick();
        wr(6'h13, 32'h0000_0302);
        repeat (3) tick();
        events[2] = 1'b0;
        tick();
        rd_expect("edge enabled mid-pulse", 6'h23, 32'd0, 32'd0);
        wr(6'h11, 32'd0);
        wr(6'h12, 32'd0);
        wr(6'h13, 32'd0);

        // Wrap with interrupt on counter 1
        wr(6'h11, 32'h0000_0104);
        wr(6'h21, 32'hFFFF_FFFE);
        wr(6'h02, 32'h0000_0002);
        events[4] = 1'b1;
        tick();
        tick();
        check_irq("irq not yet", 1'b0);
        tick();
        check_irq("irq after wrap", 1'b1);
        events[4] = 1'b0;
        rd_expect("wrap cnt1", 6'h21, 32'd1, 32'd1);
        rd_expect("wrap ovf", 6'h01, 32'h2, 32'h2);
        wr(6'h21, 32'hFFFF_FFFF);
        events[4] = 1'b1;
        wr(6'h01, 32'h0000_0002);
        events[4] = 1'b0;
        rd_expect("w1c vs new ovf", 6'h01, 32'h2, 32'h2);
        wr(6'h01, 32'h0000_0002);
        rd_expect("w1c clears", 6'h01, 32'h0, 32'h0);
        tick();
        check_irq("irq cleared", 1'b0);

        // Saturate on counter 0 (8-bit bank saturates, 32-bit bank keeps counting)
        wr(6'h10, 32'h0000_0505);
        wr(6'h20, 32'h0000_00FD);
        events[5] = 1'b1;
        repeat (10) tick();
        events[5] = 1'b0;
        rd_expect("sat cnt0", 6'h20, 32'h0000_0107, 32'h0000_00FF);
        rd_expect("sat ovf", 6'h01, 32'h0, 32'h1);
        rd_en = 1'b1;
        wr(6'h20, 32'h0000_0099);
        check("read during write/w32", rd_data[0], 32'h0000_0107);
        check("read during write/w8", rd_data[1], 32'h0000_00FF);
        rd_expect("after write cnt0", 6'h20, 32'h99, 32'h99);

        // Snapshot concurrent with increment, then freeze
        wr(6'h12, 32'h0000_0106);
        wr(6'h22, 32'd30);
        events[6] = 1'b1;
        repeat (10) tick();
        snapshot = 1'b1;
        tick();
        repeat (9) tick();
        events[6] = 1'b0;
        rd_expect("snap2", 6'h32, 32'd40, 32'd40);
        rd_expect("cnt2 after snap", 6'h22, 32'd50, 32'd50);
        freeze    = 1'b1;
        events[6] = 1'b1;
        repeat (4) tick();
        freeze    = 1'b0;
        events[6] = 1'b0;
        rd_expect("freeze holds", 6'h22, 32'd50, 32'd50);
        snapshot = 1'b1;
        wr(6'h22, 32'd7);
        rd_expect("snap vs write", 6'h32, 32'd50, 32'd50);
        rd_expect("cnt2 loaded", 6'h22, 32'd7, 32'd7);

        // Clear-all beats a concurrent event; out-of-range select never counts
        events[6] = 1'b1;
        wr(6'h00, 32'h0000_0003);
        events[6] = 1'b0;
        rd_expect("clear-all cnt2", 6'h22, 32'd0, 32'd0);
        rd_expect("clear-all cnt0", 6'h20, 32'd0, 32'd0);
        rd_expect("gctrl self-clear", 6'h00, 32'd1, 32'd1);
        wr(6'h13, 32'h0000_013F);
        events = '1;
        repeat (5) tick();
        events = '0;
        rd_expect("sel 63", 6'h23, 32'd0, 32'd0);

        // Randomized traffic checked cycle by cycle against the model
        for (int i = 0; i < 1500; i++) begin
            events   = NE'($urandom);
            freeze   = ($urandom_range(0, 15) == 0);
            snapshot = ($urandom_range(0, 15) == 0);
            op       = int'($urandom_range(0, 9));
            if (op <= 2) begin
                cfg_we    = 1'b1;
                cfg_wdata = $urandom;
                pick      = int'($urandom_range(0, 7));
                case (pick)
                    0: begin
                        cfg_addr  = 6'h00;
                        cfg_wdata = {30'd0, ($urandom_range(0, 31) == 0), ($urandom_range(0, 15) != 0)};
                    end
                    1: cfg_addr = 6'h01;
                    2: cfg_addr = 6'h02;
                    3, 4: begin
                        cfg_addr       = 6'(16 + $urandom_range(0, NC - 1));
                        cfg_wdata[5:0] = 6'($urandom_range(0, 20));
                        cfg_wdata[8]   = ($urandom_range(0, 3) != 0);
                    end
                    5: begin
                        cfg_addr = 6'(32 + $urandom_range(0, NC - 1));
                        if ($urandom_range(0, 1) == 1) cfg_wdata = 32'hFFFF_FFFF - $urandom_range(0, 6);
                    end
                    6: cfg_addr = 6'(48 + $urandom_range(0, NC - 1));
                    default: cfg_addr = 6'($urandom);
                endcase
                if ($urandom_range(0, 3) == 0) rd_en = 1'b1;
            end else if (op <= 6) begin
                rd_en = 1'b1;
                if ($urandom_range(0, 2) == 0) begin
                    cfg_addr = 6'($urandom);
                end else begin
                    cfg_addr = {2'($urandom_range(0, 3)), 4'($urandom_range(0, NC - 1))};
                end
            end
            tick();
        end
        freeze   = 1'b0;
        snapshot = 1'b0;

        // Reset mid-count clears everything
        wr(6'h00, 32'h1);
        wr(6'h10, 32'h0000_0100);
        wr(6'h02, 32'hF);
        wr(6'h20, 32'hFFFF_FFFF);
        events = '1;
        repeat (3) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        events  = '0;
        check_irq("irq after reset", 1'b0);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < NC; c++) begin
                rd_expect($sformatf("post-reset 0x%02h", 6'(16 * r + c)), 6'(16 * r + c), 32'd0, 32'd0);
            end
        end
        check_irq("irq stays low", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
